fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single write port of async_fifo1 among NREQ
//   requesters in the write clock domain. Each requester uses a valid/ready handshake.
//   A grant lasts for a burst of at most BURST words, or ends early when the owner drops
//   valid. The arbiter drives winc/wdata and honours wfull, so the FIFO never overflows.
// PARAMETERS
//   NREQ   4  number of requesters (>=2; need not be a power of 2)
//   DSIZE  8  data width; must equal the DSIZE of the attached FIFO
//   BURST  4  maximum words per grant (>=1)
//   IDW    $clog2(NREQ)  width of the grant index (derived; do not override)
// PORTS
//   wclk        in   1           write-domain clock; all logic on rising edge
//   wrst_n      in   1           reset, asynchronous assert, active-low
//   req_valid   in   NREQ        bit i: requester i has a word to write
//   req_data    in   NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE]
//   req_ready   out  NREQ        bit i: word i is accepted this cycle
//   wfull       in   1           FIFO full flag (registered, wclk domain)
//   winc        out  1           FIFO write enable
//   wdata       out  DSIZE       FIFO write data
//   gnt_active  out  1           a grant is held (state GRANT)
//   gnt_id      out  IDW         index of the current or last owner
// BEHAVIOUR
//   Reset (wrst_n=0, asynchronous):
//   - state=IDLE, rr_ptr=0, gnt_id=0, burst_cnt=0.
//   - Outputs: winc=0, req_ready=0, gnt_active=0, wdata=0.
//   State IDLE:
//   - No writes occur and req_ready=0.
//   - If any req_valid is set, the winner is the first set bit at or after rr_ptr,
//     searched in increasing index and wrapping from NREQ-1 to 0.
//   - gnt_id<=winner, burst_cnt<=0, next state GRANT.
//   - Arbitration latency is 1 cycle; the first write comes 1 cycle after valid is seen.
//   State GRANT (g = gnt_id), combinational outputs:
//   - winc = req_valid[g] & ~wfull.
//   - wdata = req_data[g*DSIZE +: DSIZE] while in GRANT; 0 in IDLE.
//   - req_ready[g] = ~wfull. All other req_ready bits are 0.
//   - A transfer is winc=1. A transfer increments burst_cnt.
//   Release (next state IDLE, rr_ptr <= (g==NREQ-1) ? 0 : g+1) happens when either:
//   - a transfer occurs with burst_cnt==BURST-1, or
//   - req_valid[g]==0; no write happens in that cycle.
//   wfull=1 in GRANT:
//   - Stall: winc=0, burst_cnt holds, and the grant is held (no release on full).
//   - An exception: if req_valid[g] drops while full, the grant is released.
//   Other rules:
//   - Requests from non-owners are ignored until the next IDLE. Every requester is
//     granted within NREQ grant periods, so there is no starvation.
//   - burst_cnt width is $clog2(BURST+1). BURST=1 gives one word per grant.
//   - Reset mid-burst: return to the reset state immediately. Any partial burst is
//     abandoned; words already written remain in the FIFO.
//   - gnt_active = (state==GRANT).
// TESTING
//   - Reset: assert wrst_n=0 mid-GRANT with winc=1.
//     -> winc, req_ready and gnt_active go to 0 at once; after release the first grant
//        goes to req 0 when all valid.
//   - Single requester: req 2 streams 10 words, BURST=4, wfull=0.
//     -> bursts of 4/4/2 words, each preceded by 1 IDLE cycle; gnt_id=2 throughout.
//   - Round robin: all 4 requesters valid continuously.
//     -> grant order 0,1,2,3,0 with 4 writes each; wdata matches the owner's slice.
//   - Full stall: wfull=1 for 5 cycles mid-burst after 2 words.
//     -> winc=0 and req_ready=0; burst_cnt stays 2; 2 more words follow after wfull=0.
//   - Early drop: owner 1 drops valid after 1 word while req 3 is valid.
//     -> release, IDLE, then grant to 3 (rr_ptr=2 skips the idle req 2).
//   - Random: random valid/wfull for 10k cycles with a scoreboard.
//     -> no write when wfull=1; per-requester order preserved; no word lost or duplicated.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the write port of an async FIFO among NREQ valid/ready
// requesters. Grants last up to BURST words and are released early when the owner drops valid.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  gnt_active,
  output logic [IDW-1:0]        gnt_id
);

  localparam int             CW   = $clog2(BURST + 1);
  localparam logic [CW-1:0]  LAST = CW'(BURST - 1);
  localparam logic [IDW-1:0] TOP  = IDW'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, rr_ptr_nx;
  logic [IDW-1:0] gnt_id_nx;
  logic [CW-1:0]  burst_cnt, burst_cnt_nx;
  logic [IDW-1:0] winner;

  // First set bit at or after the pointer, wrapping from NREQ-1 back to 0.
  function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && v[IDW'(idx)]) begin
        w     = IDW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner     = pick(req_valid, rr_ptr);
  assign gnt_active = (state == GRANT);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      gnt_id    <= gnt_id_nx;
      burst_cnt <= burst_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    gnt_id_nx    = gnt_id;
    burst_cnt_nx = burst_cnt;
    winc         = 1'b0;
    wdata        = '0;
    req_ready    = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          gnt_id_nx    = winner;
          burst_cnt_nx = '0;
          state_nx     = GRANT;
        end
      end
      GRANT: begin
        wdata             = req_data[gnt_id*DSIZE +: DSIZE];
        req_ready[gnt_id] = ~wfull;
        winc              = req_valid[gnt_id] & ~wfull;
        // A dropped valid releases even while full; a full FIFO alone only stalls.
        if (!req_valid[gnt_id]) begin
          state_nx  = IDLE;
          rr_ptr_nx = (gnt_id == TOP) ? '0 : gnt_id + 1'b1;
        end else if (winc) begin
          burst_cnt_nx = burst_cnt + 1'b1;
          if (burst_cnt == LAST) begin
            state_nx  = IDLE;
            rr_ptr_nx = (gnt_id == TOP) ? '0 : gnt_id + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run scored against a
// transaction-level model of the round-robin burst rules.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  gnt_active;
  logic [IDW-1:0]        gnt_id;

  logic [DSIZE-1:0] dv [NREQ];

  int vectors    = 0;
  int miscompares = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .wclk(clk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .gnt_active(gnt_active), .gnt_id(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = dv[i];
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic rand_data;
    for (int i = 0; i < NREQ; i++) dv[i] = 8'($urandom);
  endtask

  task automatic do_reset;
    req_valid = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    cyc();
    cyc();
    wrst_n = 1'b1;
  endtask

  task automatic test_reset;
    bit found;
    req_valid = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    rand_data();
    mid();
    vectors++;
    if (winc !== 1'b0 || req_ready !== 4'b0 || gnt_active !== 1'b0 || wdata !== 8'h00 || gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: winc=%b ready=%b act=%b wdata=%h id=%0d, need all 0",
               winc, req_ready, gnt_active, wdata, gnt_id);
    end
    cyc();
    wrst_n    = 1'b1;
    req_valid = 4'hF;
    found     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (gnt_id == 2'd1 && winc) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reset_reach_grant1: no write by req 1 within 40 cycles, need one");
    end
    wrst_n = 1'b0;
    #1;
    vectors++;
    if (winc !== 1'b0 || req_ready !== 4'b0 || gnt_active !== 1'b0 || gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_midburst: winc=%b ready=%b act=%b id=%0d, need 0/0/0/0",
               winc, req_ready, gnt_active, gnt_id);
    end
    cyc();
    cyc();
    wrst_n = 1'b1;
    mid();
    vectors++;
    if (gnt_active !== 1'b0 || winc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_after: act=%b winc=%b, need 0/0", gnt_active, winc);
    end
    cyc();
    mid();
    vectors++;
    if (gnt_active !== 1'b1 || gnt_id !== 2'd0 || winc !== 1'b1 || wdata !== dv[0]) begin
      miscompares++;
      $display("FAIL reset_first_grant: act=%b id=%0d winc=%b wdata=%h, need 1/0/1/%h",
               gnt_active, gnt_id, winc, wdata, dv[0]);
    end
    cyc();
  endtask

  task automatic test_single;
    int pat [13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    int sent;
    do_reset();
    sent = 0;
    for (int c = 0; c < 13; c++) begin
      req_valid = (sent < 10) ? 4'b0100 : 4'b0000;
      dv[2]     = 8'h20 + 8'(sent);
      mid();
      vectors++;
      if (winc !== 1'(pat[c]) || gnt_active !== 1'(pat[c])) begin
        miscompares++;
        $display("FAIL single_pattern c=%0d: winc=%b act=%b, need %0d", c, winc, gnt_active, pat[c]);
      end
      if (winc) begin
        vectors++;
        if (wdata !== 8'h20 + 8'(sent) || gnt_id !== 2'd2 || req_ready !== 4'b0100) begin
          miscompares++;
          $display("FAIL single_word c=%0d: wdata=%h id=%0d ready=%b, need %h/2/0100",
                   c, wdata, gnt_id, req_ready, 8'h20 + 8'(sent));
        end
        sent++;
      end
      cyc();
    end
    vectors++;
    if (sent != 10) begin
      miscompares++;
      $display("FAIL single_count: %0d words, need 10", sent);
    end
    req_valid = '0;
    mid();
    vectors++;
    if (winc !== 1'b0 || gnt_id !== 2'd2) begin
      miscompares++;
      $display("FAIL single_drop: winc=%b id=%0d, need 0/2", winc, gnt_id);
    end
    cyc();
  endtask

  task automatic test_round_robin;
    int owner, phase;
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 25; c++) begin
      rand_data();
      phase = c % 5;
      owner = (c / 5) % NREQ;
      mid();
      vectors++;
      if (phase == 0) begin
        if (winc !== 1'b0 || gnt_active !== 1'b0) begin
          miscompares++;
          $display("FAIL rr_idle c=%0d: winc=%b act=%b, need 0/0", c, winc, gnt_active);
        end
      end else if (winc !== 1'b1 || gnt_id !== IDW'(owner) || wdata !== dv[owner]
                   || req_ready !== (4'b1 << owner)) begin
        miscompares++;
        $display("FAIL rr_write c=%0d: winc=%b id=%0d wdata=%h ready=%b, need 1/%0d/%h",
                 c, winc, gnt_id, wdata, req_ready, owner, dv[owner]);
      end
      cyc();
    end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_full_stall;
    int pw [12] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1};
    int pa [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      wfull = (c >= 3 && c <= 7);
      mid();
      vectors++;
      if (winc !== 1'(pw[c]) || gnt_active !== 1'(pa[c]) ||
          req_ready !== ((pa[c] != 0 && !wfull) ? 4'b0001 : 4'b0000) ||
          (winc && wdata !== dv[0])) begin
        miscompares++;
        $display("FAIL full_stall c=%0d: winc=%b act=%b ready=%b wdata=%h, need %0d/%0d",
                 c, winc, gnt_active, req_ready, wdata, pw[c], pa[c]);
      end
      cyc();
    end
    req_valid = '0;
    wfull     = 1'b0;
    cyc();
  endtask

  task automatic test_early_drop;
    do_reset();
    rand_data();
    req_valid = 4'b1010;
    mid();
    cyc();
    mid();
    vectors++;
    if (winc !== 1'b1 || gnt_id !== 2'd1 || req_ready !== 4'b0010 || wdata !== dv[1]) begin
      miscompares++;
      $display("FAIL drop_first: winc=%b id=%0d ready=%b wdata=%h, need 1/1/0010/%h",
               winc, gnt_id, req_ready, wdata, dv[1]);
    end
    cyc();
    req_valid = 4'b1000;
    mid();
    vectors++;
    if (winc !== 1'b0 || gnt_active !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_release: winc=%b act=%b, need 0/1", winc, gnt_active);
    end
    cyc();
    mid();
    vectors++;
    if (gnt_active !== 1'b0 || winc !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: act=%b winc=%b, need 0/0", gnt_active, winc);
    end
    cyc();
    mid();
    vectors++;
    if (gnt_active !== 1'b1 || gnt_id !== 2'd3 || winc !== 1'b1 || wdata !== dv[3]) begin
      miscompares++;
      $display("FAIL drop_next_owner: act=%b id=%0d winc=%b wdata=%h, need 1/3/1/%h",
               gnt_active, gnt_id, winc, wdata, dv[3]);
    end
    cyc();
    req_valid = '0;
    cyc();
  endtask

  task automatic test_random;
    // Reference: grant holder, words in current grant, next search start.
    bit              m_act;
    int              m_owner, m_cnt, m_ptr;
    int              seq [NREQ];
    logic [NREQ-1:0] acc, exp_ready;
    logic            exp_winc;
    int              writes, accepts;
    do_reset();
    m_act = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    writes = 0; accepts = 0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    acc = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          seq[i]++;
          req_valid[i] = 1'($urandom % 2);
        end else if (req_valid[i]) begin
          req_valid[i] = ($urandom % 10) != 0;
        end else begin
          req_valid[i] = 1'($urandom % 2);
        end
        dv[i] = 8'(i * 64 + seq[i] % 64);
      end
      wfull = ($urandom % 4) == 0;
      mid();
      exp_winc  = m_act && req_valid[m_owner] && !wfull;
      exp_ready = (m_act && !wfull) ? (4'b1 << m_owner) : 4'b0;
      vectors++;
      if (gnt_active !== m_act || gnt_id !== IDW'(m_owner) || winc !== exp_winc ||
          req_ready !== exp_ready || (winc && wdata !== dv[m_owner]) || (winc && wfull)) begin
        miscompares++;
        $display("FAIL random c=%0d: act=%b id=%0d winc=%b ready=%b wdata=%h full=%b, need %b/%0d/%b/%b/%h",
                 c, gnt_active, gnt_id, winc, req_ready, wdata, wfull,
                 m_act, m_owner, exp_winc, exp_ready, dv[m_owner]);
      end
      acc = req_valid & req_ready;
      if (winc) writes++;
      accepts += $countones(acc);
      if (!m_act) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!m_act && req_valid[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            m_act   = 1;
            m_cnt   = 0;
          end
        end
      end else if (!req_valid[m_owner]) begin
        m_act = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end else if (!wfull) begin
        m_cnt++;
        if (m_cnt == BURST) begin
          m_act = 0;
          m_ptr = (m_owner + 1) % NREQ;
        end
      end
      cyc();
    end
    vectors++;
    if (writes != accepts || writes < 1000) begin
      miscompares++;
      $display("FAIL random_totals: writes=%0d handshakes=%0d, need equal and >=1000", writes, accepts);
    end
    req_valid = '0;
    wfull     = 1'b0;
    cyc();
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = '0;
    wfull     = 1'b0;
    for (int i = 0; i < NREQ; i++) dv[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
